rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin priority; 0 selects fixed priority (bit 7 highest).
REQ-002 Parameter MAX_HOLD, default 15: maximum cycles one grant may be held; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  8  request per requester; bit i belongs to requester i; level-sensitive.
REQ-006 done  input  1  single-cycle release pulse from the shared resource; valid only while grant_valid=1.
REQ-007 grant  output  8  one-hot grant; all zero when no grant is active.
REQ-008 grant_id  output  3  index of the granted requester; 0 when grant_valid=0.
REQ-009 grant_valid  output  1  high while a grant is held.
REQ-010 timeout  output  1  single-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The block shall be a 2-state FSM: IDLE and GRANT.
REQ-012 In IDLE with req≠0, the block shall pick a winner and enter GRANT on the next edge; grant, grant_id and grant_valid are registered, so latency is exactly 1 cycle from req to grant.
REQ-013 In IDLE with req=0, the block shall remain in IDLE with all outputs zero.
REQ-014 Fixed mode shall pick the highest set index (7 down to 0).
REQ-015 Round-robin mode shall search from index (last_id−1) mod 8 downward with wrap to 7; last_id is the most recently granted index.
REQ-016 last_id shall reset to 0, so the first round-robin order is 7,6,…,0 and matches fixed mode.
REQ-017 In GRANT, the block shall return to IDLE on the next edge if done=1, if req[grant_id]=0, or if hold_cnt reaches MAX_HOLD−1.
REQ-018 Each GRANT→IDLE transition shall be followed by at least one IDLE cycle before the next grant (one-cycle bubble), so back-to-back grants are 1 cycle apart at minimum.
REQ-019 hold_cnt (8 bits) shall clear on entry to GRANT and increment each GRANT cycle; it shall never wrap, because the limit is checked first.
REQ-020 timeout shall pulse 1 cycle, coincident with the IDLE cycle, only when the hold limit caused the release; done or a req drop in the same cycle takes precedence and suppresses timeout.
REQ-021 last_id shall update on entry to GRANT.
REQ-022 Changes to req bits other than req[grant_id] during GRANT shall have no effect until the next IDLE.
REQ-023 done received in IDLE shall be ignored.
REQ-024 grant shall always equal 1<<grant_id when grant_valid=1, and grant_valid shall equal |grant.

Reset
REQ-025 When rst_n=0, the block shall immediately force IDLE, clear grant, grant_id, grant_valid and timeout to 0, and clear hold_cnt and last_id to 0, including mid-grant.
REQ-026 After rst_n rises, the first arbitration shall occur at the first edge with req≠0.

Structure
REQ-027 Package arb_pkg shall hold the state enum (IDLE, GRANT), the constant NUM_REQ=8 and the type for the 3-bit id.
REQ-028 Winner selection shall be a combinational sub-module, prio_enc8 (8-bit in, 3-bit index out, plus valid), driven with the request vector rotated by last_id in round-robin mode; the index is then rotated back.

Verification
REQ-029 Reset, then req=8'b0000_0101 with RR_EN=0 -> one cycle later grant=8'b0000_0100, grant_id=2, grant_valid=1.
REQ-030 RR_EN=1, req=8'hFF held, done pulsed on the first GRANT cycle each time -> grant_id sequence 7,6,5,…,0,7, with one IDLE cycle between grants.
REQ-031 MAX_HOLD=4, req[3] held, no done -> grant_valid high for exactly 4 cycles, then timeout=1 for 1 cycle with grant_valid=0, then req[3] is re-granted.
REQ-032 Grant to id 5; drop req[5] and pulse done in the same cycle -> IDLE next cycle with timeout=0; drop req[5] alone -> IDLE next cycle.
REQ-033 rst_n asserted mid-grant (asynchronously, between edges) -> outputs are 0 immediately; after release with req=8'h81, RR_EN=1 -> grant_id=7.
REQ-034 A random req/done run of at least 10k cycles with checks -> grant stays one-hot or zero, REQ-024 holds, and no requester held high waits more than 8 grants.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way arbiter: state encoding, requester
// count, id type and the rotation helper used for round-robin search.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef logic [ID_W-1:0]    arb_id_t;
    typedef logic [NUM_REQ-1:0] arb_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // result[j] = v[(j + n) mod NUM_REQ]; the 3-bit add wraps naturally
    function automatic arb_vec_t rotr(input arb_vec_t v, input arb_id_t n);
        arb_vec_t r;
        arb_id_t  src;
        r   = '0;
        src = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            src  = arb_id_t'(j) + n;
            r[j] = v[src];
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder: reports the highest set bit and
// whether any bit is set.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    arb_id_t pos;

    // Ascending scan: the last hit, i.e. the highest index, wins
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = arb_id_t'(i);
            if (req_i[pos]) begin
                idx_o   = pos;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// 8-requester arbiter with round-robin or fixed priority, a hold limit per
// grant and a mandatory one-cycle idle bubble between grants.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    arb_state_e state_q;
    arb_vec_t   grant_q;
    arb_id_t    grant_id_q;
    logic       grant_valid_q;
    logic       timeout_q;
    arb_id_t    last_id_q;
    logic [7:0] hold_cnt_q;

    arb_id_t    offset;
    arb_vec_t   rot_req;
    arb_id_t    enc_idx;
    logic       enc_valid;
    arb_id_t    winner_d;
    arb_vec_t   grant_d;
    logic [7:0] hold_cnt_d;
    logic       held_req;
    logic       hit_limit;

    // Rotating by last_id puts index (last_id-1) at the encoder's top bit,
    // so the highest-first scan becomes the round-robin search order.
    always_comb begin
        offset     = (RR_EN != 0) ? last_id_q : '0;
        rot_req    = rotr(req, offset);
        winner_d   = enc_idx + offset;
        grant_d    = arb_vec_t'(1) << winner_d;
        hold_cnt_d = hold_cnt_q + 8'd1;
        held_req   = req[grant_id_q];
        hit_limit  = (hold_cnt_q == HOLD_LIMIT);
    end

    prio_enc8 u_enc (
        .req_i   (rot_req),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            last_id_q     <= '0;
            hold_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (enc_valid) begin
                        state_q       <= GRANT;
                        grant_q       <= grant_d;
                        grant_id_q    <= winner_d;
                        grant_valid_q <= 1'b1;
                        last_id_q     <= winner_d;
                        hold_cnt_q    <= '0;
                    end
                end
                GRANT: begin
                    if (done || !held_req || hit_limit) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        grant_id_q    <= '0;
                        grant_valid_q <= 1'b0;
                        // A release by done or req drop masks the limit
                        timeout_q     <= !done && held_req;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: two instances (round-robin with hold limit 4, fixed with
// default limit) share stimulus and are compared to a behavioural model.
module tb_rr_arb8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [7:0] rr_grant, fx_grant;
    logic [2:0] rr_id, fx_id;
    logic       rr_valid, fx_valid;
    logic       rr_to, fx_to;

    rr_arb8 #(.RR_EN(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(rr_grant), .grant_id(rr_id), .grant_valid(rr_valid), .timeout(rr_to)
    );

    rr_arb8 #(.RR_EN(0), .MAX_HOLD(15)) u_fx (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(fx_grant), .grant_id(fx_id), .grant_valid(fx_valid), .timeout(fx_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_busy [2] = '{0, 0};
    int         m_id   [2] = '{0, 0};
    int         m_last [2] = '{0, 0};
    int         m_held [2] = '{0, 0};
    bit         m_to   [2] = '{0, 0};
    logic [7:0] req_seen = '0;
    int         rst_cnt = 0;

    function automatic int is_rr(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int max_hold(input int k);
        return (k == 0) ? 4 : 15;
    endfunction

    function automatic int pick(input int k, input logic [7:0] r, input int last);
        int c;
        if (is_rr(k) != 0) begin
            for (int s = 1; s <= 8; s++) begin
                c = (last - s + 8) % 8;
                if (r[c[2:0]]) return c;
            end
        end else begin
            for (int s = 7; s >= 0; s--) begin
                if (r[s[2:0]]) return s;
            end
        end
        return 0;
    endfunction

    function automatic logic [12:0] expv(input int k);
        logic [7:0] g;
        logic [2:0] id;
        g  = '0;
        id = '0;
        if (m_busy[k] != 0) begin
            id = m_id[k][2:0];
            g  = 8'(1) << m_id[k];
        end
        return {g, id, (m_busy[k] != 0), m_to[k]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_id[k] = 0; m_last[k] = 0; m_held[k] = 0; m_to[k] = 0;
            end
            rst_cnt++;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k] == 0) begin
                    m_to[k] = 0;
                    if (req != 8'h00) begin
                        m_id[k]   = pick(k, req, m_last[k]);
                        m_last[k] = m_id[k];
                        m_busy[k] = 1;
                        m_held[k] = 1;
                    end
                end else if (done || !req[m_id[k][2:0]]) begin
                    m_busy[k] = 0;
                    m_to[k]   = 0;
                end else if (m_held[k] == max_hold(k)) begin
                    m_busy[k] = 0;
                    m_to[k]   = 1;
                end else begin
                    m_held[k]++;
                end
            end
            req_seen = req;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [12:0] act_rr, act_fx;
    assign act_rr = {rr_grant, rr_id, rr_valid, rr_to};
    assign act_fx = {fx_grant, fx_id, fx_valid, fx_to};

    int   wait_cnt [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic prev_rr_valid = 1'b0;
    int   seen_rst = 0;
    int   worst;

    always @(negedge clk) begin
        chk("rr_vs_model", 32'(act_rr), 32'(expv(0)));
        chk("fx_vs_model", 32'(act_fx), 32'(expv(1)));
        chk("rr_consistent",
            {29'd0, rr_valid == |rr_grant,
             rr_grant == (rr_valid ? (8'(1) << rr_id) : 8'h00),
             rr_valid || rr_id == 3'd0}, 32'd7);
        chk("fx_consistent",
            {29'd0, fx_valid == |fx_grant,
             fx_grant == (fx_valid ? (8'(1) << fx_id) : 8'h00),
             fx_valid || fx_id == 3'd0}, 32'd7);

        // Fairness of the round-robin instance, counted in grants observed
        if (seen_rst != rst_cnt) begin
            seen_rst = rst_cnt;
            for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        end
        for (int i = 0; i < 8; i++)
            if (!req_seen[i]) wait_cnt[i] = 0;
        if (rr_valid && !prev_rr_valid) begin
            worst = 0;
            for (int i = 0; i < 8; i++) begin
                if (req_seen[i]) begin
                    if (i == int'(rr_id)) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                end
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            chk("rr_fair_wait_over_8", 32'(worst > 8), 32'd0);
        end
        prev_rr_valid = rr_valid;
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (3) cyc();
        chk("reset_rr_outputs", 32'(act_rr), 32'd0);
        chk("reset_fx_outputs", 32'(act_fx), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_no_req", 32'(act_rr), 32'd0);

        // Fixed priority, two requesters
        req = 8'b0000_0101;
        cyc();
        chk("fx_grant_101", 32'(fx_grant), 32'h04);
        chk("fx_id_101", 32'(fx_id), 32'd2);
        chk("fx_valid_101", 32'(fx_valid), 32'd1);
        req = 8'h00;
        cyc();
        chk("fx_drop_valid", 32'(fx_valid), 32'd0);
        chk("fx_drop_timeout", 32'(fx_to), 32'd0);

        // Round-robin rotation from a fresh reset
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("rr_seq_id", 32'(rr_id), 32'((15 - i) % 8));
            chk("rr_seq_valid", 32'(rr_valid), 32'd1);
            chk("fx_seq_id", 32'(fx_id), 32'd7);
            done = 1'b1;
            cyc();
            chk("rr_seq_bubble", 32'(rr_valid), 32'd0);
            done = 1'b0;
        end

        // Hold limit of 4 on the round-robin instance
        req = 8'h08;
        cyc();
        chk("hold_first_id", 32'(rr_id), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_still_valid", 32'(rr_valid), 32'd1);
        end
        cyc();
        chk("hold_released", 32'(rr_valid), 32'd0);
        chk("hold_timeout", 32'(rr_to), 32'd1);
        cyc();
        chk("hold_regrant", {29'd0, rr_valid, rr_to, rr_id == 3'd3}, 32'b101);
        repeat (3) cyc();
        chk("limit_cycle_valid", 32'(rr_valid), 32'd1);
        done = 1'b1;
        cyc();
        chk("done_beats_limit", {30'd0, rr_valid, rr_to}, 32'd0);
        done = 1'b0;
        req  = 8'h00;
        cyc();

        // Drop with done, then drop alone
        req = 8'h20;
        cyc();
        chk("id5_grant", 32'(rr_id), 32'd5);
        req  = 8'h00;
        done = 1'b1;
        cyc();
        chk("drop_done_release", {30'd0, rr_valid, rr_to}, 32'd0);
        done = 1'b0;
        req  = 8'h20;
        cyc();
        chk("id5_regrant", 32'(rr_grant), 32'h20);
        req = 8'h00;
        cyc();
        chk("drop_alone_release", {30'd0, rr_valid, rr_to}, 32'd0);

        // Asynchronous reset in the middle of a grant
        req = 8'h20;
        cyc();
        chk("pre_reset_valid", 32'(rr_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rr", 32'(act_rr), 32'd0);
        chk("async_reset_fx", 32'(act_fx), 32'd0);
        req = 8'h81;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_id", 32'(rr_id), 32'd7);
        chk("post_reset_valid", 32'(rr_valid), 32'd1);

        // Random run
        req  = 8'h00;
        done = 1'b0;
        for (int n = 0; n < 12000; n++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) req = req ^ 8'($urandom);
            if ($urandom_range(0, 31) == 0) req = 8'h00;
            done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2999) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
